dmem_axil_bridge: RTL and testbench
===================================

DMEM_AXIL_BRIDGE -- requirements
Module: dmem_axil_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_mem  in  1  core data request (load or store).
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- wdata  in  32  store data, lane-aligned.
- wmask  in  4  store byte enables.
- rdata  out  32  load data returned to the core.
- data_stall  out  1  core must hold its MEM stage.
- data_err  out  1  bus error for the completed access.
- m_awvalid/m_awready/m_awaddr/m_awprot  out/in/out/out  1/1/ADDR_W/3  AXI4-Lite write address channel.
- m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/32/4  AXI4-Lite write data channel.
- m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  AXI4-Lite write response channel.
- m_arvalid/m_arready/m_araddr/m_arprot  out/in/out/out  1/1/ADDR_W/3  AXI4-Lite read address channel.
- m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/32/2  AXI4-Lite read data channel.

Function
REQ-003 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
REQ-004 SHALL accept a request only in IDLE or DONE: req_mem=1 at a clk edge latches addr/wdata/wmask/we and moves to WADDR (we=1) or RADDR (we=0). req_mem in any other state SHALL be ignored.
REQ-005 SHALL drive m_awaddr/m_araddr = {latched addr[ADDR_W-1:2], 2'b00}, m_awprot = m_arprot = 3'b000, m_wdata = latched wdata, m_wstrb = latched wmask.
REQ-006 WADDR: m_awvalid and m_wvalid SHALL both assert on entry.
- Each SHALL deassert independently the cycle after its own handshake (tracked by aw_done and w_done flags).
- The state SHALL move to WRESP once both handshakes have occurred, in either order or in the same cycle.
REQ-007 WRESP: m_bready=1; on m_bvalid SHALL capture err = m_bresp[1] and go to DONE.
REQ-008 RADDR: m_arvalid=1; on m_arready SHALL go to RDATA.
REQ-009 RDATA: m_rready=1; on m_rvalid SHALL register rdata <= m_rdata, capture err = m_rresp[1], and go to DONE.
REQ-010 DONE SHALL last exactly one cycle with data_stall=0 and data_err=err. It SHALL go to IDLE, or start a new access if req_mem=1 (back-to-back).
REQ-011 data_stall SHALL be 1 in WADDR, WRESP, RADDR and RDATA, and 0 in IDLE and DONE. Minimum access latency is therefore request edge + 3 cycles to DONE with zero-wait slaves.
REQ-012 data_err SHALL be 0 outside DONE. On an error, rdata SHALL still be updated with m_rdata.
REQ-013 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-014 A store with wmask=4'b0000 SHALL still be issued on the bus with m_wstrb=0.
REQ-015 At most one transaction SHALL be outstanding; AW/W and AR SHALL never be asserted concurrently.
REQ-016 All valid/ready outputs SHALL be registered or decoded directly from state; none SHALL depend combinationally on an AXI input.

Reset
REQ-017 On reset: state=IDLE; all valid/ready outputs 0; data_stall=0; data_err=0; rdata=0; latched request registers 0.
REQ-018 Reset asserted mid-transaction SHALL abandon the access immediately, with no completion or error reported.

Structure
REQ-019 Package dmem_axil_pkg SHALL hold the state enum, the AXI resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), and the PROT constant 3'b000.
REQ-020 The block SHALL be a single module with no sub-module; the AW/W flag logic SHALL stay inline.

Verification
REQ-021 Zero-wait read: req_mem=1, we=0, addr=32'h0000_1006, slave returns 32'hDEAD_BEEF OKAY -> m_araddr=32'h0000_1004; data_stall high 3 cycles; DONE shows rdata=DEAD_BEEF, data_err=0.
REQ-022 Write with W before AW: wdata=32'h1234_5678, wmask=4'b0011; m_wready at cycle 1, m_awready at cycle 3, bresp OKAY -> m_wvalid drops after cycle 1; WRESP is entered only after AW; m_wstrb=4'b0011.
REQ-023 Error response: read with rresp=SLVERR -> data_err=1 for exactly one cycle in DONE; rdata updated.
REQ-024 Back-to-back: req_mem held during DONE with a store following a load -> new AW/W is issued the cycle after DONE; the stored load rdata is unchanged.
REQ-025 Slave stalls 5 cycles on m_arready and on m_rvalid -> m_arvalid stays asserted and stable until the handshake; data_stall stays 1 throughout.
REQ-026 Reset asserted in WRESP -> all valids/readies 0 and data_stall=0 immediately; a subsequent read completes normally.

Source files
------------

// File: rtl/dmem_axil_pkg.sv
// Shared types and constants for the core data-memory to AXI4-Lite bridge.
package dmem_axil_pkg;

    // Bridge sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_e;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT = 3'b000;

    // SLVERR and DECERR both carry bit 1 set; EXOKAY is not used on AXI4-Lite.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/dmem_axil_bridge.sv
// Bridges the core's single-cycle data request port onto an AXI4-Lite master.
// One access is in flight at a time; the core is stalled until it completes,
// and the completion is visible for exactly one cycle in DONE.
module dmem_axil_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_mem,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wmask,
    output logic [31:0]       rdata,
    output logic              data_stall,
    output logic              data_err,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp
);
    import dmem_axil_pkg::*;

    state_e              state_q, state_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                err_q, err_d;
    logic [ADDR_W-3:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wmask_q;
    logic [31:0]         rdata_q;
    logic                accept;
    logic                rd_capture;
    logic                aw_hs;
    logic                w_hs;

    // Byte offset and response bit 0 carry no information for word-aligned AXI-Lite.
    logic unused_bits;
    assign unused_bits = ^{addr, m_bresp[0], m_rresp[0]};

    // Valid/ready are pure decodes of state and done flags, never of AXI inputs.
    assign m_awvalid  = (state_q == WADDR) && !aw_done_q;
    assign m_wvalid   = (state_q == WADDR) && !w_done_q;
    assign m_bready   = (state_q == WRESP);
    assign m_arvalid  = (state_q == RADDR);
    assign m_rready   = (state_q == RDATA);
    assign data_stall = (state_q == WADDR) || (state_q == WRESP) ||
                        (state_q == RADDR) || (state_q == RDATA);
    assign data_err   = (state_q == DONE) && err_q;

    assign m_awaddr   = {addr_q, 2'b00};
    assign m_araddr   = {addr_q, 2'b00};
    assign m_awprot   = AXI_PROT;
    assign m_arprot   = AXI_PROT;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wmask_q;
    assign rdata      = rdata_q;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    // Next-state decode: request acceptance, AW/W join, response capture.
    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        err_d      = err_q;
        accept     = 1'b0;
        rd_capture = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (req_mem) begin
                    accept    = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we ? WADDR : RADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            WADDR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m_bvalid) begin
                    err_d   = resp_is_err(m_bresp);
                    state_d = DONE;
                end
            end
            RADDR: begin
                if (m_arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (m_rvalid) begin
                    rd_capture = 1'b1;
                    err_d      = resp_is_err(m_rresp);
                    state_d    = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, channel-done flags and the completion error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Request latch: holds the bus-facing address/data for the whole access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            addr_q  <= addr[ADDR_W-1:2];
            wdata_q <= wdata;
            wmask_q <= wmask;
        end
    end

    // Load data register: updated only by a completed read, even on error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_capture) begin
            rdata_q <= m_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Scenario bench for dmem_axil_bridge with a configurable AXI4-Lite slave.
module tb_dmem_axil_bridge;
    import dmem_axil_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_mem = 1'b0;
    logic              we = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        wmask = '0;
    logic [31:0]       rdata;
    logic              data_stall, data_err;
    logic              m_awvalid, m_awready, m_wvalid, m_wready;
    logic [ADDR_W-1:0] m_awaddr, m_araddr;
    logic [2:0]        m_awprot, m_arprot;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]        m_bresp, m_rresp;
    logic [31:0]       m_rdata;

    always #5 clk = ~clk;

    dmem_axil_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_mem(req_mem), .we(we), .addr(addr),
        .wdata(wdata), .wmask(wmask), .rdata(rdata), .data_stall(data_stall),
        .data_err(data_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    // Slave configuration and data, set by each scenario.
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = RESP_OKAY;
    logic [1:0]  s_bresp = RESP_OKAY;
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_bresp = s_bresp;

    // Manual override of the slave handshake signals.
    logic manual = 1'b0;
    logic man_awready = 1'b0, man_wready = 1'b0, man_bvalid = 1'b0;
    logic a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
    assign m_awready = manual ? man_awready : a_awready;
    assign m_wready  = manual ? man_wready  : a_wready;
    assign m_bvalid  = manual ? man_bvalid  : a_bvalid;
    assign m_arready = manual ? 1'b0        : a_arready;
    assign m_rvalid  = manual ? 1'b0        : a_rvalid;

    wire aw_hs_tb = m_awvalid && m_awready;
    wire w_hs_tb  = m_wvalid && m_wready;

    int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, b_pend, aw_got, w_got;

    // Auto slave: readies are registered responses to valid, after a programmable delay.
    always @(posedge clk or posedge reset) begin
        if (reset || manual) begin
            a_awready <= 0; a_wready <= 0; a_bvalid <= 0; a_arready <= 0; a_rvalid <= 0;
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 0; b_pend <= 0; aw_got <= 0; w_got <= 0;
        end else begin
            if (a_arready && m_arvalid) begin
                a_arready <= 0;
                if (r_dly == 0) a_rvalid <= 1;
                else begin r_pend <= 1; r_cnt <= 1; end
            end else if (m_arvalid && !a_arready) begin
                if (ar_cnt >= ar_dly) begin a_arready <= 1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (a_rvalid && m_rready) a_rvalid <= 0;
            else if (r_pend) begin
                if (r_cnt >= r_dly) begin a_rvalid <= 1; r_pend <= 0; end
                else r_cnt <= r_cnt + 1;
            end
            if (aw_hs_tb) begin a_awready <= 0; aw_got <= 1; end
            else if (m_awvalid && !a_awready) begin
                if (aw_cnt >= aw_dly) begin a_awready <= 1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (w_hs_tb) begin a_wready <= 0; w_got <= 1; end
            else if (m_wvalid && !a_wready) begin
                if (w_cnt >= w_dly) begin a_wready <= 1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if ((aw_got || aw_hs_tb) && (w_got || w_hs_tb)) begin
                aw_got <= 0; w_got <= 0;
                if (b_dly == 0) a_bvalid <= 1;
                else begin b_pend <= 1; b_cnt <= 1; end
            end
            if (a_bvalid && m_bready) a_bvalid <= 0;
            else if (b_pend) begin
                if (b_cnt >= b_dly) begin a_bvalid <= 1; b_pend <= 0; end
                else b_cnt <= b_cnt + 1;
            end
        end
    end

    // Watch for write and read channels being driven at the same time.
    logic conc_seen = 1'b0;
    always @(negedge clk) begin
        if ((m_awvalid || m_wvalid) && m_arvalid) conc_seen <= 1'b1;
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] rd;
        logic        err;
        logic [31:0] baddr;
        logic [3:0]  strb;
        logic [31:0] bdata;
        logic        err_busy;
        logic        err_after;
        logic        stall_after;
    } obs_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = '0;
    int          passed = 0;
    int          total = 0;

    // Issue one access and record what the DUT showed; no judging here.
    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, output obs_t o);
        o = '0;
        @(negedge clk);
        req_mem = 1'b1; we = w; addr = a; wdata = d; wmask = m;
        @(negedge clk);
        req_mem = 1'b0;
        o.baddr = w ? m_awaddr : m_araddr;
        o.strb  = m_wstrb;
        o.bdata = m_wdata;
        while (data_stall === 1'b1 && o.cyc < 200) begin
            o.cyc = o.cyc + 1;
            if (data_err !== 1'b0) o.err_busy = 1'b1;
            @(negedge clk);
        end
        o.rd  = rdata;
        o.err = data_err;
        @(negedge clk);
        o.err_after   = data_err;
        o.stall_after = data_stall;
    endtask

    task automatic push_exp(input logic w);
        exp_t e;
        if (!w) model_rdata = s_rdata;
        e.rdata = model_rdata;
        e.err   = w ? s_bresp[1] : s_rresp[1];
        e.cyc   = w ? 32'((aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 3) : 32'(ar_dly + r_dly + 3);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [4:0] hs;
        @(negedge clk);
        hs = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
        total++; if (hs !== 5'b0) $display("FAIL reset_handshakes got %b want 00000", hs); else passed++;
        total++; if ({data_stall, data_err} !== 2'b00) $display("FAIL reset_stall_err got %b want 00", {data_stall, data_err}); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else passed++;
        total++; if ({m_awaddr, m_wdata, m_wstrb} !== '0) $display("FAIL reset_latch got %h %h %h want 0", m_awaddr, m_wdata, m_wstrb); else passed++;
        total++; if ({m_awprot, m_arprot} !== {AXI_PROT, AXI_PROT}) $display("FAIL reset_prot got %b %b want 000", m_awprot, m_arprot); else passed++;
    endtask

    task automatic test_zero_wait_read();
        obs_t o; exp_t e;
        ar_dly = 0; r_dly = 0; s_rdata = 32'hDEAD_BEEF; s_rresp = RESP_OKAY;
        push_exp(1'b0);
        run_access(1'b0, 32'h0000_1006, 32'h0, 4'h0, o);
        e = sb.pop_front();
        total++; if (o.baddr !== 32'h0000_1004) $display("FAIL zw_araddr got %h want 00001004", o.baddr); else passed++;
        total++; if (o.cyc !== e.cyc) $display("FAIL zw_stall_cycles got %0d want %0d", o.cyc, e.cyc); else passed++;
        total++; if (o.rd !== e.rdata) $display("FAIL zw_rdata got %h want %h", o.rd, e.rdata); else passed++;
        total++; if ({o.err, o.err_busy, o.err_after} !== {e.err, 2'b00}) $display("FAIL zw_err got %b%b%b want %b00", o.err, o.err_busy, o.err_after, e.err); else passed++;
    endtask

    task automatic test_write_w_before_aw();
        exp_t e;
        manual = 1'b1; man_awready = 0; man_wready = 0; man_bvalid = 0; s_bresp = RESP_OKAY;
        push_exp(1'b1);
        @(negedge clk);
        req_mem = 1; we = 1; addr = 32'h0000_2000; wdata = 32'h1234_5678; wmask = 4'b0011;
        @(negedge clk);
        req_mem = 0; man_wready = 1;
        total++; if ({m_awvalid, m_wvalid, m_wstrb} !== {2'b11, 4'b0011}) $display("FAIL wb_entry got %b%b %b want 11 0011", m_awvalid, m_wvalid, m_wstrb); else passed++;
        @(negedge clk);
        man_wready = 0;
        total++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b100) $display("FAIL wb_w_drop got %b want 100", {m_awvalid, m_wvalid, m_bready}); else passed++;
        total++; if (m_wdata !== 32'h1234_5678) $display("FAIL wb_wdata got %h want 12345678", m_wdata); else passed++;
        @(negedge clk);
        man_awready = 1;
        total++; if ({m_awvalid, m_bready, data_stall} !== 3'b101) $display("FAIL wb_wait_aw got %b want 101", {m_awvalid, m_bready, data_stall}); else passed++;
        @(negedge clk);
        man_awready = 0;
        total++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) $display("FAIL wb_wresp got %b want 001", {m_awvalid, m_wvalid, m_bready}); else passed++;
        man_bvalid = 1;
        @(negedge clk);
        man_bvalid = 0;
        e = sb.pop_front();
        total++; if ({data_stall, data_err} !== {1'b0, e.err}) $display("FAIL wb_done got %b want 0%b", {data_stall, data_err}, e.err); else passed++;
        total++; if (rdata !== e.rdata) $display("FAIL wb_rdata_kept got %h want %h", rdata, e.rdata); else passed++;
        @(negedge clk);
        manual = 1'b0;
    endtask

    task automatic test_zero_mask_store();
        obs_t o; exp_t e;
        aw_dly = 0; w_dly = 0; b_dly = 0; s_bresp = RESP_OKAY;
        push_exp(1'b1);
        run_access(1'b1, 32'h0000_3003, 32'hFFFF_FFFF, 4'b0000, o);
        e = sb.pop_front();
        total++; if ({o.baddr, o.strb, o.bdata} !== {32'h0000_3000, 4'b0000, 32'hFFFF_FFFF}) $display("FAIL zm_bus got %h %b %h want 00003000 0000 ffffffff", o.baddr, o.strb, o.bdata); else passed++;
        total++; if (o.cyc !== e.cyc) $display("FAIL zm_stall_cycles got %0d want %0d", o.cyc, e.cyc); else passed++;
        total++; if ({o.rd, o.err} !== {e.rdata, e.err}) $display("FAIL zm_done got %h %b want %h %b", o.rd, o.err, e.rdata, e.err); else passed++;
    endtask

    task automatic test_error_response();
        obs_t o; exp_t e;
        s_rdata = 32'hCAFE_F00D; s_rresp = RESP_SLVERR;
        push_exp(1'b0);
        run_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, o);
        e = sb.pop_front();
        total++; if ({o.err, o.err_busy, o.err_after} !== {e.err, 2'b00}) $display("FAIL rerr_pulse got %b%b%b want %b00", o.err, o.err_busy, o.err_after, e.err); else passed++;
        total++; if (o.rd !== e.rdata) $display("FAIL rerr_rdata got %h want %h", o.rd, e.rdata); else passed++;
        s_rresp = RESP_OKAY; s_bresp = RESP_DECERR;
        push_exp(1'b1);
        run_access(1'b1, 32'h0000_0200, 32'h1111_2222, 4'b1111, o);
        e = sb.pop_front();
        total++; if ({o.err, o.err_after} !== {e.err, 1'b0}) $display("FAIL werr_pulse got %b%b want %b0", o.err, o.err_after, e.err); else passed++;
        total++; if (o.rd !== e.rdata) $display("FAIL werr_rdata_kept got %h want %h", o.rd, e.rdata); else passed++;
        s_bresp = RESP_OKAY;
    endtask

    task automatic test_slave_stall();
        exp_t e;
        int cyc, ar_cyc;
        logic ar_bad, ar_ended;
        ar_dly = 5; r_dly = 5; s_rdata = 32'h5A5A_1234; s_rresp = RESP_OKAY;
        push_exp(1'b0);
        @(negedge clk);
        req_mem = 1; we = 0; addr = 32'h0000_0040;
        @(negedge clk);
        req_mem = 0;
        cyc = 0; ar_cyc = 0; ar_bad = 0; ar_ended = 0;
        while (data_stall === 1'b1 && cyc < 200) begin
            cyc++;
            if (m_arvalid === 1'b1) begin
                ar_cyc++;
                if (ar_ended || m_araddr !== 32'h0000_0040) ar_bad = 1;
            end else if (ar_cyc > 0) ar_ended = 1;
            @(negedge clk);
        end
        e = sb.pop_front();
        total++; if (ar_cyc !== ar_dly + 2 || ar_bad) $display("FAIL st_arvalid got %0d cycles bad=%b want %0d stable", ar_cyc, ar_bad, ar_dly + 2); else passed++;
        total++; if (32'(cyc) !== e.cyc) $display("FAIL st_stall_cycles got %0d want %0d", cyc, e.cyc); else passed++;
        total++; if ({rdata, data_err} !== {e.rdata, e.err}) $display("FAIL st_done got %h %b want %h %b", rdata, data_err, e.rdata, e.err); else passed++;
        ar_dly = 0; r_dly = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cyc;
        s_rdata = 32'h0BAD_C0DE; s_rresp = RESP_OKAY; s_bresp = RESP_OKAY;
        push_exp(1'b0);
        @(negedge clk);
        req_mem = 1; we = 0; addr = 32'h0000_0500;
        @(negedge clk);
        req_mem = 0; cyc = 0;
        while (data_stall === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        e = sb.pop_front();
        total++; if ({rdata, data_err} !== {e.rdata, e.err}) $display("FAIL b2b_load got %h %b want %h %b", rdata, data_err, e.rdata, e.err); else passed++;
        push_exp(1'b1);
        req_mem = 1; we = 1; addr = 32'h0000_3008; wdata = 32'hA5A5_5A5A; wmask = 4'b1111;
        @(negedge clk);
        req_mem = 0;
        total++; if ({m_awvalid, m_wvalid, data_stall, m_awaddr} !== {3'b111, 32'h0000_3008}) $display("FAIL b2b_issue got %b%b%b %h want 111 00003008", m_awvalid, m_wvalid, data_stall, m_awaddr); else passed++;
        cyc = 0;
        while (data_stall === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        e = sb.pop_front();
        total++; if (32'(cyc) !== e.cyc) $display("FAIL b2b_store_cycles got %0d want %0d", cyc, e.cyc); else passed++;
        total++; if ({rdata, data_err} !== {e.rdata, e.err}) $display("FAIL b2b_rdata_kept got %h %b want %h %b", rdata, data_err, e.rdata, e.err); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wresp();
        obs_t o; exp_t e;
        int n;
        b_dly = 10;
        @(negedge clk);
        req_mem = 1; we = 1; addr = 32'h0000_0700; wdata = 32'h7777_7777; wmask = 4'b1111;
        @(negedge clk);
        req_mem = 0; n = 0;
        while (m_bready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
        total++; if (m_bready !== 1'b1) $display("FAIL rst_reach_wresp got %b want 1", m_bready); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, data_stall, data_err} !== 7'b0) $display("FAIL rst_abandon got %b want 0000000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, data_stall, data_err}); else passed++;
        model_rdata = 32'h0;
        total++; if (rdata !== model_rdata) $display("FAIL rst_rdata got %h want %h", rdata, model_rdata); else passed++;
        @(negedge clk); @(negedge clk);
        reset = 1'b0; b_dly = 0;
        s_rdata = 32'h600D_F00D; s_rresp = RESP_OKAY;
        push_exp(1'b0);
        run_access(1'b0, 32'h0000_0800, 32'h0, 4'h0, o);
        e = sb.pop_front();
        total++; if ({o.cyc, o.rd, o.err} !== {e.cyc, e.rdata, e.err}) $display("FAIL rst_recover got %0d %h %b want %0d %h %b", o.cyc, o.rd, o.err, e.cyc, e.rdata, e.err); else passed++;
    endtask

    task automatic test_no_concurrency();
        total++; if (conc_seen !== 1'b0) $display("FAIL no_concurrent_aw_ar got %b want 0", conc_seen); else passed++;
        total++; if (sb.size() !== 0) $display("FAIL scoreboard_drained got %0d want 0", sb.size()); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_zero_wait_read();
        test_write_w_before_aw();
        test_zero_mask_store();
        test_error_response();
        test_slave_stall();
        test_back_to_back();
        test_reset_in_wresp();
        test_no_concurrency();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
